// File: rtl/des_pkg.sv
// ============================================================================
// Module  : des_pkg
// Purpose : Shared DES tables, types and helpers for the iterative round
//           controller. Provides the IP/FP/PC1/PC2 permutations, the
//           per-round rotation schedule, the FSM state type and widths.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package des_pkg;

    localparam int unsigned RND_W = 5;

    typedef logic [1:32]      half_t;
    typedef logic [1:48]      subkey_t;
    typedef logic [1:28]      cd_half_t;
    typedef logic [RND_W-1:0] rnd_t;

    localparam rnd_t LAST_RND = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    // Rotation amount per round, index 0 = round 1. Decrypt rotates right and
    // starts with 0 because C16/D16 equal C0/D0 after a full encrypt schedule.
    localparam logic [1:0] ENC_SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    localparam logic [1:0] DEC_SHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    function automatic logic [1:64] ip(input logic [1:64] x);
        logic [1:64] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[i+1] = x[IP_TAB[i]];
        return y;
    endfunction

    function automatic logic [1:64] fp(input logic [1:64] x);
        logic [1:64] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[i+1] = x[FP_TAB[i]];
        return y;
    endfunction

    function automatic logic [1:56] pc1(input logic [1:64] x);
        logic [1:56] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[i+1] = x[PC1_TAB[i]];
        return y;
    endfunction

    function automatic subkey_t pc2(input logic [1:56] x);
        subkey_t y;
        y = '0;
        for (int i = 0; i < 48; i++) y[i+1] = x[PC2_TAB[i]];
        return y;
    endfunction

    function automatic logic [1:0] shift_amt(input rnd_t rnd, input logic dec);
        logic [3:0] idx;
        idx = 4'(rnd - 5'd1);
        return dec ? DEC_SHIFT[idx] : ENC_SHIFT[idx];
    endfunction

    function automatic cd_half_t rot(input cd_half_t x, input logic [1:0] amt,
                                     input logic dec);
        cd_half_t y;
        y = x;
        if (dec) begin
            if (amt == 2'd1)      y = {x[28], x[1:27]};
            else if (amt == 2'd2) y = {x[27:28], x[1:26]};
        end else begin
            if (amt == 2'd1)      y = {x[2:28], x[1]};
            else if (amt == 2'd2) y = {x[3:28], x[1:2]};
        end
        return y;
    endfunction

endpackage

`default_nettype wire

// File: rtl/des_key_schedule.sv
// ============================================================================
// Module  : des_key_schedule
// Purpose : C/D key-schedule registers with per-round rotation and PC2.
// Ports   : clk, rst_n      - clock, async active-low reset
//           load_i, key_i   - load C/D from PC1(key_i)
//           step_i          - advance one round (also enables subkey_o)
//           decrypt_i       - rotation direction select
//           rnd_i           - current round number 1..16
//           subkey_o        - PC2 of the rotated C/D, 0 when not stepping
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [1:64] key_i,
    input  logic        step_i,
    input  logic        decrypt_i,
    input  rnd_t        rnd_i,
    output subkey_t     subkey_o
);

    cd_half_t    c_q, c_d, d_q, d_d;
    cd_half_t    c_rot, d_rot;
    logic [1:0]  amt;
    logic [1:56] key_pc1;

    // The subkey for the current round comes from the already-rotated C/D,
    // so the rotation is combinational and the rotated value is what gets
    // stored at the round edge.
    always_comb begin
        amt     = shift_amt(rnd_i, decrypt_i);
        c_rot   = rot(c_q, amt, decrypt_i);
        d_rot   = rot(d_q, amt, decrypt_i);
        key_pc1 = pc1(key_i);
        c_d     = c_q;
        d_d     = d_q;
        if (load_i) begin
            c_d = key_pc1[1:28];
            d_d = key_pc1[29:56];
        end else if (step_i) begin
            c_d = c_rot;
            d_d = d_rot;
        end
    end

    assign subkey_o = step_i ? pc2({c_rot, d_rot}) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
            d_q <= '0;
        end else begin
            c_q <= c_d;
            d_q <= d_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/des_round_controller.sv
// ============================================================================
// Module  : des_round_controller
// Purpose : Iterative DES controller: one block per transaction, 16 Feistel
//           rounds one per clock, external round function via f_* ports.
// Ports   : clk, rst_n                     - clock, async active-low reset
//           in_valid/in_ready              - input handshake (ready in IDLE)
//           in_decrypt, in_block, in_key   - mode, data and key at accept
//           out_valid/out_ready, out_block - result handshake and data
//           f_right, f_subkey, f_result    - external round function I/F
//           busy                           - high in ROUND or DONE
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module des_round_controller
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [1:64] in_block,
    input  logic [1:64] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:64] out_block,
    output logic [1:32] f_right,
    output logic [1:48] f_subkey,
    input  logic [1:32] f_result,
    output logic        busy
);

    state_e      state_q, state_d;
    half_t       l_q, l_d, r_q, r_d;
    rnd_t        rnd_q, rnd_d;
    logic        mode_q, mode_d;
    logic [1:64] out_q, out_d;
    logic [1:64] ip_block;
    half_t       r_next;
    logic        load;
    logic        in_round;

    assign in_round = (state_q == ST_ROUND);
    assign r_next   = l_q ^ f_result;

    always_comb begin
        state_d  = state_q;
        l_d      = l_q;
        r_d      = r_q;
        rnd_d    = rnd_q;
        mode_d   = mode_q;
        out_d    = out_q;
        load     = 1'b0;
        ip_block = ip(in_block);
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    l_d     = ip_block[1:32];
                    r_d     = ip_block[33:64];
                    mode_d  = in_decrypt;
                    rnd_d   = 5'd1;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                l_d   = r_q;
                r_d   = r_next;
                rnd_d = rnd_q + 5'd1;
                if (rnd_q == LAST_RND) begin
                    // Final swap: output is FP(R16 || L16), L16 being R15.
                    out_d   = fp({r_next, r_q});
                    rnd_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            rnd_q   <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            rnd_q   <= rnd_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

    des_key_schedule u_key_schedule (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .key_i     (in_key),
        .step_i    (in_round),
        .decrypt_i (mode_q),
        .rnd_i     (rnd_q),
        .subkey_o  (f_subkey)
    );

    assign f_right   = in_round ? r_q : '0;
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_ROUND) || (state_q == ST_DONE);
    assign out_block = out_q;

endmodule

`default_nettype wire

// File: tb/tb_des_round_controller.sv
// ============================================================================
// Module  : tb_des_round_controller
// Purpose : Self-checking bench: real DES round function on the f_* ports,
//           known-answer vectors plus random transactions against a
//           behavioural DES model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_des_round_controller;
    import des_pkg::ip;
    import des_pkg::fp;
    import des_pkg::pc1;
    import des_pkg::pc2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_decrypt = 1'b0;
    logic [1:64] in_block = '0;
    logic [1:64] in_key = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:64] out_block;
    logic [1:32] f_right;
    logic [1:48] f_subkey;
    logic [1:32] f_result;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    logic [1:48] cap_sk [1:16];

    localparam int E_TAB [48] = '{
        32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,  16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32, 1};
    localparam int P_TAB [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    // S-box rows: entry 4*box+row, nibble for column 0 is the most significant.
    localparam logic [63:0] SB [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    function automatic logic [1:32] f_fn(input logic [1:32] r, input logic [1:48] k);
        logic [1:48] x;
        logic [1:32] s;
        logic [1:32] p;
        logic [5:0]  six;
        logic [63:0] rowv;
        int          row, col;
        x = '0; s = '0; p = '0;
        for (int i = 0; i < 48; i++) x[i+1] = r[E_TAB[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six  = x[b*6+1 +: 6];
            row  = {30'd0, six[5], six[0]};
            col  = {28'd0, six[4:1]};
            rowv = SB[b*4+row];
            s[b*4+1 +: 4] = rowv[(15-col)*4 +: 4];
        end
        for (int i = 0; i < 32; i++) p[i+1] = s[P_TAB[i]];
        return p;
    endfunction

    // Encrypt subkey i: C0/D0 rotated left by the cumulative shift count,
    // 2 per round minus one for each of rounds 1, 2, 9 and 16 reached.
    function automatic logic [1:48] ref_subkey(input logic [1:64] key, input int i);
        logic [1:56] cd;
        logic [27:0] c, d;
        int          n;
        cd = pc1(key);
        c  = cd[1:28];
        d  = cd[29:56];
        n  = 2 * i - 1 - ((i >= 2) ? 1 : 0) - ((i >= 9) ? 1 : 0) - ((i >= 16) ? 1 : 0);
        c  = (c << n) | (c >> (28 - n));
        d  = (d << n) | (d >> (28 - n));
        return pc2({c, d});
    endfunction

    function automatic logic [1:48] ref_round_key(input logic [1:64] key, input int i,
                                                  input logic dec);
        return ref_subkey(key, dec ? (17 - i) : i);
    endfunction

    function automatic logic [1:64] des_ref(input logic [1:64] key, input logic [1:64] blk,
                                           input logic dec);
        logic [1:64] lr;
        logic [1:32] l, r, t;
        lr = ip(blk);
        l  = lr[1:32];
        r  = lr[33:64];
        for (int i = 1; i <= 16; i++) begin
            t = r;
            r = l ^ f_fn(r, ref_round_key(key, i, dec));
            l = t;
        end
        return fp({r, l});
    endfunction

    assign f_result = f_fn(f_right, f_subkey);

    des_round_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_decrypt (in_decrypt),
        .in_block   (in_block),
        .in_key     (in_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_block  (out_block),
        .f_right    (f_right),
        .f_subkey   (f_subkey),
        .f_result   (f_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Runs one transaction; lat = edges from accept to out_valid (-1 if the
    // controller never became ready). Returns at the negedge where out_valid
    // is seen; if hold_ready, also lets the DONE->IDLE edge pass.
    task automatic do_txn(input logic [1:64] key, input logic [1:64] blk, input logic dec,
                          input logic hold_ready, output logic [1:64] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        res = '0;
        lat = -1;
        if (in_ready) begin
            in_valid = 1'b1; in_key = key; in_block = blk; in_decrypt = dec;
            out_ready = hold_ready;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_block = {$urandom, $urandom};
            in_decrypt = ~dec;
            lat = 0;
            cap_sk[1] = f_subkey;
            while (!out_valid && lat < 40) begin
                @(negedge clk);
                lat++;
                if (lat <= 15) cap_sk[lat+1] = f_subkey;
            end
            res = out_block;
            if (hold_ready) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (out_block !== 64'h0) begin n_err++; $display("FAIL reset_out_block got %h want 0", out_block); end
        n_vec++; if (f_right !== 32'h0 || f_subkey !== 48'h0) begin n_err++; $display("FAIL reset_f_ports got %h/%h want 0/0", f_right, f_subkey); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_encrypt_kat;
        logic [1:64] res; int lat;
        do_txn(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 1'b1, res, lat);
        n_vec++; if (res !== 64'h85E813540F0AB405) begin n_err++; $display("FAIL enc_kat got %h want 85e813540f0ab405", res); end
        n_vec++; if (lat !== 16) begin n_err++; $display("FAIL enc_latency got %0d want 16", lat); end
        n_vec++; if (cap_sk[1] !== 48'h1B02EFFC7072) begin n_err++; $display("FAIL enc_k1 got %h want 1b02effc7072", cap_sk[1]); end
        for (int i = 1; i <= 16; i++) begin
            n_vec++;
            if (cap_sk[i] !== ref_round_key(64'h133457799BBCDFF1, i, 1'b0)) begin
                n_err++; $display("FAIL enc_subkey_r%0d got %h want %h", i, cap_sk[i], ref_round_key(64'h133457799BBCDFF1, i, 1'b0));
            end
        end
    endtask

    task automatic test_decrypt_kat;
        logic [1:64] res; int lat;
        do_txn(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 1'b1, res, lat);
        n_vec++; if (res !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL dec_kat got %h want 0123456789abcdef", res); end
        for (int i = 1; i <= 16; i++) begin
            n_vec++;
            if (cap_sk[i] !== ref_round_key(64'h133457799BBCDFF1, i, 1'b1)) begin
                n_err++; $display("FAIL dec_subkey_r%0d got %h want %h", i, cap_sk[i], ref_round_key(64'h133457799BBCDFF1, i, 1'b1));
            end
        end
    endtask

    task automatic test_zero;
        logic [1:64] res; int lat;
        do_txn(64'h0, 64'h0, 1'b0, 1'b1, res, lat);
        n_vec++; if (res !== 64'h8CA64DE9C1B123A7) begin n_err++; $display("FAIL zero_kat got %h want 8ca64de9c1b123a7", res); end
        n_vec++; if (cap_sk[1] !== 48'h0) begin n_err++; $display("FAIL zero_k1 got %h want 0", cap_sk[1]); end
    endtask

    task automatic test_backpressure;
        logic [1:64] res; logic [1:64] exp; int lat;
        exp = des_ref(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0);
        do_txn(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 1'b0, res, lat);
        n_vec++; if (res !== exp) begin n_err++; $display("FAIL bp_result got %h want %h", res, exp); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom); in_block = {$urandom, $urandom}; in_decrypt = 1'($urandom);
            @(negedge clk);
            n_vec++;
            if (out_block !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold_c%0d got %h/v%b/r%b want %h/v1/r0", i, out_block, out_valid, in_ready, exp);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got v%b/r%b want v0/r1", out_valid, in_ready); end
    endtask

    task automatic test_mid_reset;
        logic [1:64] res; int lat; logic seen;
        in_valid = 1'b1; in_key = 64'h133457799BBCDFF1; in_block = 64'h0123456789ABCDEF; in_decrypt = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mr_busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_block !== 64'h0 || f_right !== 32'h0 || f_subkey !== 48'h0) begin
            n_err++; $display("FAIL mr_async got v%b b%b ob%h fr%h fk%h want all 0", out_valid, busy, out_block, f_right, f_subkey);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mr_no_partial got seen%b r%b want seen0 r1", seen, in_ready); end
        do_txn(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 1'b1, res, lat);
        n_vec++; if (res !== 64'h85E813540F0AB405) begin n_err++; $display("FAIL mr_fresh got %h want 85e813540f0ab405", res); end
    endtask

    task automatic test_back_to_back;
        logic [1:64] res1, res2; int k, k2, first_valid, first_ready;
        res1 = '0; res2 = '0; first_valid = -1; first_ready = -1;
        in_valid = 1'b1; in_key = 64'h133457799BBCDFF1; in_block = 64'h0123456789ABCDEF; in_decrypt = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_block = 64'h85E813540F0AB405;
        in_decrypt = 1'b1;
        k = 0;
        while (k < 18) begin
            @(negedge clk);
            k++;
            if (out_valid && first_valid < 0) begin first_valid = k; res1 = out_block; end
            if (in_ready && first_ready < 0) first_ready = k;
        end
        n_vec++; if (first_valid !== 16) begin n_err++; $display("FAIL b2b_lat1 got %0d want 16", first_valid); end
        n_vec++; if (first_ready !== 17) begin n_err++; $display("FAIL b2b_ready got %0d want 17", first_ready); end
        n_vec++; if (res1 !== 64'h85E813540F0AB405) begin n_err++; $display("FAIL b2b_res1 got %h want 85e813540f0ab405", res1); end
        n_vec++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept2 got b%b r%b want b1 r0", busy, in_ready); end
        in_valid = 1'b0;
        k2 = 0;
        while (!out_valid && k2 < 40) begin
            @(negedge clk);
            k2++;
        end
        res2 = out_block;
        n_vec++; if (k2 !== 16) begin n_err++; $display("FAIL b2b_lat2 got %0d want 16", k2); end
        n_vec++; if (res2 !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL b2b_res2 got %h want 0123456789abcdef", res2); end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [1:64] key, blk, res, exp; logic dec; int lat;
        for (int t = 0; t < 12; t++) begin
            key = {$urandom, $urandom};
            blk = {$urandom, $urandom};
            dec = 1'($urandom);
            exp = des_ref(key, blk, dec);
            do_txn(key, blk, dec, 1'b1, res, lat);
            n_vec++;
            if (res !== exp || lat !== 16) begin
                n_err++; $display("FAIL rand_t%0d got %h lat%0d want %h lat16 (key %h blk %h dec %b)", t, res, lat, exp, key, blk, dec);
            end
            n_vec++;
            if (cap_sk[9] !== ref_round_key(key, 9, dec)) begin
                n_err++; $display("FAIL rand_k9_t%0d got %h want %h", t, cap_sk[9], ref_round_key(key, 9, dec));
            end
        end
    endtask

    initial begin
        test_reset();
        test_encrypt_kat();
        test_decrypt_kat();
        test_zero();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
